decode_dispatch_sequencer: RTL and testbench

- Sits between fetch and the bank of format-specific decoders (A, B, D, X, ... formats) in the decode stage.
- Buffers fetched instructions in a small FIFO and issues them in order, one per cycle, to exactly one format decoder via a one-hot enable.
- Holds issue while the backend stalls or while a decoder is busy emitting micro-ops, and flags instructions whose format vector is not one-hot.

---
 rtl/decode_dispatch_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_decode_dispatch_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_sequencer.sv
// Buffers fetched instructions and issues them in order, one per cycle, to a single format decoder.
// Latency: push into an empty FIFO at edge k issues at edge k+1; sustained throughput 1/cycle.
// Backpressure: ready_o drops at full (no bypass); stall_i or a busy decoder holds issue while pushes continue.
module decode_dispatch_sequencer #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int formatCount             = 26,
    parameter int fifoDepth               = 4,
    parameter int issueCountWidth         = 32
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic                                 enable_i,
    output logic                                 ready_o,
    input  logic [0:formatCount-1]               instFormat_i,
    input  logic [0:instructionWidth-1]          instruction_i,
    input  logic [0:addressWidth-1]              instructionAddress_i,
    input  logic [0:PidSize-1]                   instructionPid_i,
    input  logic [0:TidSize-1]                   instructionTid_i,
    input  logic [0:instructionCounterWidth-1]   instructionMajId_i,
    input  logic                                 stall_i,
    input  logic [0:formatCount-1]               decoderBusy_i,
    output logic [0:formatCount-1]               decoderEnable_o,
    output logic [0:instructionWidth-1]          instruction_o,
    output logic [0:addressWidth-1]              instructionAddress_o,
    output logic [0:PidSize-1]                   instructionPid_o,
    output logic [0:TidSize-1]                   instructionTid_o,
    output logic [0:instructionCounterWidth-1]   instructionMajId_o,
    output logic                                 formatError_o,
    output logic [0:issueCountWidth-1]           issueCount_o
);

    localparam int PtrWidth = $clog2(fifoDepth);
    localparam int CntWidth = $clog2(fifoDepth + 1);

    typedef struct packed {
        logic [0:formatCount-1]             fmt;
        logic [0:instructionWidth-1]        inst;
        logic [0:addressWidth-1]            addr;
        logic [0:PidSize-1]                 pid;
        logic [0:TidSize-1]                 tid;
        logic [0:instructionCounterWidth-1] maj_id;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2
    } state_t;

    entry_t                 mem [fifoDepth];
    entry_t                 wr_entry;
    entry_t                 head;
    logic [PtrWidth-1:0]    wr_ptr;
    logic [PtrWidth-1:0]    rd_ptr;
    logic [CntWidth-1:0]    count;
    logic [CntWidth-1:0]    count_nxt;
    state_t                 state;
    state_t                 state_nxt;
    logic [0:formatCount-1] last_fmt;
    logic                   push;
    logic                   pop;
    logic                   issue_ok;
    logic                   head_onehot;
    logic                   busy_hit;
    logic                   last_busy;

    assign wr_entry.fmt    = instFormat_i;
    assign wr_entry.inst   = instruction_i;
    assign wr_entry.addr   = instructionAddress_i;
    assign wr_entry.pid    = instructionPid_i;
    assign wr_entry.tid    = instructionTid_i;
    assign wr_entry.maj_id = instructionMajId_i;

    assign head        = mem[rd_ptr];
    assign head_onehot = (head.fmt != '0) &&
                         ((head.fmt & (head.fmt - formatCount'(1))) == '0);

    assign ready_o = (count != CntWidth'(fifoDepth));
    assign push    = enable_i && ready_o;

    // Busy is only looked at in the cycle right after a real issue; error issues never enable a decoder.
    assign busy_hit  = |(decoderEnable_o & decoderBusy_i);
    assign last_busy = |(last_fmt & decoderBusy_i);

    // The cycle that sees the busy decoder release is the one that issues the next entry.
    assign issue_ok = ((state == ISSUE) && !busy_hit) ||
                      ((state == WAIT_BUSY) && !last_busy);
    assign pop      = issue_ok && (count != '0) && !stall_i;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CntWidth'(1);
        end else if (!push && pop) begin
            count_nxt = count - CntWidth'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (count_nxt != '0) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (busy_hit) begin
                    state_nxt = WAIT_BUSY;
                end else if (!pop && (count_nxt == '0)) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (!last_busy) begin
                    state_nxt = (pop || (count_nxt != '0)) ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            decoderEnable_o      <= '0;
            formatError_o        <= 1'b0;
            issueCount_o         <= '0;
            last_fmt             <= '0;
            instruction_o        <= '0;
            instructionAddress_o <= '0;
            instructionPid_o     <= '0;
            instructionTid_o     <= '0;
            instructionMajId_o   <= '0;
        end else begin
            decoderEnable_o <= '0;
            formatError_o   <= 1'b0;
            if (pop) begin
                instruction_o        <= head.inst;
                instructionAddress_o <= head.addr;
                instructionPid_o     <= head.pid;
                instructionTid_o     <= head.tid;
                instructionMajId_o   <= head.maj_id;
                if (head_onehot) begin
                    decoderEnable_o <= head.fmt;
                    last_fmt        <= head.fmt;
                    issueCount_o    <= issueCount_o + issueCountWidth'(1);
                end else begin
                    formatError_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_dispatch_sequencer.sv
// Directed bench for decode_dispatch_sequencer; issue counter narrowed to 4 bits so wrap is reachable.
module tb_decode_dispatch_sequencer;

    localparam int AW = 64;
    localparam int IW = 32;
    localparam int PW = 20;
    localparam int TW = 16;
    localparam int CW = 64;
    localparam int FC = 26;
    localparam int FD = 4;
    localparam int NW = 4;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          enable_i = 1'b0;
    logic          ready_o;
    logic [0:FC-1] instFormat_i = '0;
    logic [0:IW-1] instruction_i = '0;
    logic [0:AW-1] instructionAddress_i = '0;
    logic [0:PW-1] instructionPid_i = '0;
    logic [0:TW-1] instructionTid_i = '0;
    logic [0:CW-1] instructionMajId_i = '0;
    logic          stall_i = 1'b0;
    logic [0:FC-1] decoderBusy_i = '0;
    logic [0:FC-1] decoderEnable_o;
    logic [0:IW-1] instruction_o;
    logic [0:AW-1] instructionAddress_o;
    logic [0:PW-1] instructionPid_o;
    logic [0:TW-1] instructionTid_o;
    logic [0:CW-1] instructionMajId_o;
    logic          formatError_o;
    logic [0:NW-1] issueCount_o;

    int passed = 0;
    int total  = 0;

    decode_dispatch_sequencer #(
        .addressWidth(AW), .instructionWidth(IW), .PidSize(PW), .TidSize(TW),
        .instructionCounterWidth(CW), .formatCount(FC), .fifoDepth(FD), .issueCountWidth(NW)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .ready_o(ready_o),
        .instFormat_i(instFormat_i), .instruction_i(instruction_i),
        .instructionAddress_i(instructionAddress_i), .instructionPid_i(instructionPid_i),
        .instructionTid_i(instructionTid_i), .instructionMajId_i(instructionMajId_i),
        .stall_i(stall_i), .decoderBusy_i(decoderBusy_i), .decoderEnable_o(decoderEnable_o),
        .instruction_o(instruction_o), .instructionAddress_o(instructionAddress_o),
        .instructionPid_o(instructionPid_o), .instructionTid_o(instructionTid_o),
        .instructionMajId_o(instructionMajId_o), .formatError_o(formatError_o),
        .issueCount_o(issueCount_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [0:FC-1] fbit(input int i);
        logic [0:FC-1] f;
        f    = '0;
        f[i] = 1'b1;
        return f;
    endfunction

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [0:FC-1] f, input logic [63:0] maj);
        enable_i             = 1'b1;
        instFormat_i         = f;
        instruction_i        = 32'hC0DE_0000 + maj[31:0];
        instructionAddress_i = 64'h4000_0000 + (maj << 2);
        instructionPid_i     = 20'h12345;
        instructionTid_i     = 16'hBEEF;
        instructionMajId_i   = maj;
    endtask

    task automatic idle();
        enable_i     = 1'b0;
        instFormat_i = '0;
    endtask

    task automatic do_reset();
        idle();
        stall_i       = 1'b0;
        decoderBusy_i = '0;
        reset_i       = 1'b0;
        step();
        step();
        #2 reset_i = 1'b1;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_enable", decoderEnable_o, 0);
        check("rst_error", formatError_o, 0);
        check("rst_count", issueCount_o, 0);
        check("rst_majid", instructionMajId_o, 0);
        check("rst_inst", instruction_o, 0);
        check("rst_ready", ready_o, 1);
        #2 reset_i = 1'b1;

        // Three back-to-back B-format instructions
        drive(fbit(1), 0);
        step();
        check("t1_latency", decoderEnable_o, 0);
        drive(fbit(1), 1);
        step();
        check("t1_en0", decoderEnable_o, fbit(1));
        check("t1_maj0", instructionMajId_o, 0);
        check("t1_inst0", instruction_o, 32'hC0DE_0000);
        drive(fbit(1), 2);
        step();
        check("t1_en1", decoderEnable_o, fbit(1));
        check("t1_maj1", instructionMajId_o, 1);
        idle();
        step();
        check("t1_en2", decoderEnable_o, fbit(1));
        check("t1_maj2", instructionMajId_o, 2);
        check("t1_addr2", instructionAddress_o, 64'h4000_0008);
        step();
        check("t1_en_done", decoderEnable_o, 0);
        check("t1_count", issueCount_o, 3);

        // Stall while filling past capacity
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(fbit(i), 10 + i);
            step();
            check("t2_stall_en", decoderEnable_o, 0);
            check("t2_ready", ready_o, (i < 3) ? 1 : 0);
        end
        drive(fbit(4), 14);
        step();
        check("t2_full_ready", ready_o, 0);
        check("t2_full_en", decoderEnable_o, 0);
        idle();
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_drain_en", decoderEnable_o, fbit(i));
            check("t2_drain_maj", instructionMajId_o, 10 + i);
            check("t2_drain_ready", ready_o, 1);
        end
        step();
        check("t2_no_fifth", decoderEnable_o, 0);
        check("t2_maj_hold", instructionMajId_o, 13);
        check("t2_count", issueCount_o, 4);

        // Decoder 3 busy for three cycles after its enable
        do_reset();
        drive(fbit(3), 20);
        step();
        drive(fbit(4), 21);
        step();
        check("t3_en_fmt3", decoderEnable_o, fbit(3));
        decoderBusy_i = fbit(3);
        drive(fbit(5), 22);
        step();
        check("t3_busy_c1", decoderEnable_o, 0);
        idle();
        step();
        check("t3_busy_c2", decoderEnable_o, 0);
        step();
        check("t3_busy_c3", decoderEnable_o, 0);
        decoderBusy_i = '0;
        step();
        check("t3_resume_en", decoderEnable_o, fbit(4));
        check("t3_resume_maj", instructionMajId_o, 21);
        step();
        check("t3_next_en", decoderEnable_o, fbit(5));
        check("t3_next_maj", instructionMajId_o, 22);
        step();
        check("t3_done_en", decoderEnable_o, 0);
        check("t3_count", issueCount_o, 3);

        // Non-one-hot formats
        do_reset();
        drive('0, 30);
        step();
        check("t4_pre_err", formatError_o, 0);
        drive(fbit(2) | fbit(5), 31);
        step();
        check("t4_err0", formatError_o, 1);
        check("t4_err0_en", decoderEnable_o, 0);
        check("t4_err0_maj", instructionMajId_o, 30);
        drive(fbit(0), 32);
        step();
        check("t4_err1", formatError_o, 1);
        check("t4_err1_en", decoderEnable_o, 0);
        check("t4_err1_maj", instructionMajId_o, 31);
        idle();
        step();
        check("t4_valid_en", decoderEnable_o, fbit(0));
        check("t4_valid_err", formatError_o, 0);
        check("t4_valid_maj", instructionMajId_o, 32);
        step();
        check("t4_done_en", decoderEnable_o, 0);
        check("t4_count", issueCount_o, 1);

        // Asynchronous reset with two entries buffered
        do_reset();
        drive(fbit(1), 39);
        step();
        drive(fbit(1), 40);
        step();
        check("t5_pre_en", decoderEnable_o, fbit(1));
        check("t5_pre_maj", instructionMajId_o, 39);
        stall_i = 1'b1;
        drive(fbit(2), 41);
        step();
        check("t5_pre_ready", ready_o, 1);
        check("t5_pre_count", issueCount_o, 1);
        idle();
        #2 reset_i = 1'b0;
        #1;
        check("t5_async_count", issueCount_o, 0);
        check("t5_async_maj", instructionMajId_o, 0);
        check("t5_async_inst", instruction_o, 0);
        check("t5_async_ready", ready_o, 1);
        #2 reset_i = 1'b1;
        stall_i = 1'b0;
        step();
        check("t5_no_stale0", decoderEnable_o, 0);
        check("t5_ready", ready_o, 1);
        step();
        check("t5_no_stale1", decoderEnable_o, 0);
        check("t5_no_err", formatError_o, 0);
        check("t5_count", issueCount_o, 0);

        // Issue counter wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(fbit(7), 50 + i);
            step();
        end
        check("t6_all_ones", issueCount_o, 4'hF);
        idle();
        step();
        check("t6_wrap_en", decoderEnable_o, fbit(7));
        check("t6_wrap_maj", instructionMajId_o, 65);
        check("t6_wrap", issueCount_o, 0);
        step();
        check("t6_done_en", decoderEnable_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
